// File: rtl/attention_head_scheduler.sv
// Arbitrates attention jobs round-robin onto one engine, issuing one start per masked head (lowest first) under a watchdog.
// Start follows acceptance by one cycle; the completion record follows the last done by one cycle and holds until cmp_ready.
module attention_head_scheduler #(
   parameter int NREQ    = 4,
   parameter int HEADS   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 255,
   localparam int IW = (NREQ  > 1) ? $clog2(NREQ)  : 1,
   localparam int HW = (HEADS > 1) ? $clog2(HEADS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*HEADS-1:0] req_head_mask,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic                  eng_start,
   output logic [HW-1:0]         eng_head,
   input  logic                  eng_done,
   input  logic                  eng_err,
   output logic                  cmp_valid,
   input  logic                  cmp_ready,
   output logic [IW-1:0]         cmp_req_id,
   output logic [TAG_W-1:0]      cmp_tag,
   output logic                  cmp_err,
   output logic                  cmp_timeout,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_last;
   logic [IW-1:0]    r_id;
   logic [HEADS-1:0] r_mask;
   logic [TAG_W-1:0] r_tag;
   logic [HW-1:0]    r_head;
   logic [15:0]      r_cnt;
   logic             r_err;
   logic             r_tmo;
   logic             r_start;
   logic             r_cvld;
   logic             r_busy;

   logic             w_win_vld;
   logic [IW-1:0]    w_win_id;
   logic [IW-1:0]    w_idx;
   logic [HEADS-1:0] w_sel_mask;
   logic [TAG_W-1:0] w_sel_tag;
   logic [HEADS-1:0] w_mask_left;
   logic [15:0]      w_cnt_nxt;
   logic             w_expire;

   function automatic logic [HW-1:0] f_lsb(input logic [HEADS-1:0] m);
      f_lsb = '0;
      for (int i = HEADS - 1; i >= 0; i--) begin
         if (m[i]) f_lsb = HW'(i);
      end
   endfunction

   // Search starts just past the last granted requester and wraps.
   always_comb begin
      w_win_vld  = 1'b0;
      w_win_id   = '0;
      w_idx      = '0;
      w_sel_mask = '0;
      w_sel_tag  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         w_idx = IW'((int'(r_last) + i) % NREQ);
         if (!w_win_vld && req_valid[w_idx]) begin
            w_win_vld = 1'b1;
            w_win_id  = w_idx;
         end
      end
      for (int r = 0; r < NREQ; r++) begin
         if (w_win_id == IW'(r)) begin
            w_sel_mask = req_head_mask[r*HEADS +: HEADS];
            w_sel_tag  = req_tag[r*TAG_W +: TAG_W];
         end
      end
   end

   assign w_mask_left = r_mask & ~(HEADS'(1) << r_head);
   assign w_cnt_nxt   = r_cnt + 16'd1;
   assign w_expire    = (w_cnt_nxt == 16'(TIMEOUT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_last  <= IW'(NREQ - 1);
         r_id    <= '0;
         r_mask  <= '0;
         r_tag   <= '0;
         r_head  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_tmo   <= 1'b0;
         r_start <= 1'b0;
         r_cvld  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_id   <= w_win_id;
                  r_tag  <= w_sel_tag;
                  r_mask <= w_sel_mask;
                  r_head <= f_lsb(w_sel_mask);
                  r_err  <= 1'b0;
                  r_tmo  <= 1'b0;
                  r_busy <= 1'b1;
                  if (|w_sel_mask) begin
                     r_start <= 1'b1;
                     r_state <= S_ISSUE;
                  end else begin
                     r_cvld  <= 1'b1;
                     r_state <= S_REPORT;
                  end
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               // A done landing on the expiry cycle still wins over the watchdog.
               if (eng_done) begin
                  r_err  <= r_err | eng_err;
                  r_mask <= w_mask_left;
                  if (|w_mask_left) begin
                     r_head  <= f_lsb(w_mask_left);
                     r_start <= 1'b1;
                     r_state <= S_ISSUE;
                  end else begin
                     r_cvld  <= 1'b1;
                     r_state <= S_REPORT;
                  end
               end else if (w_expire) begin
                  r_tmo   <= 1'b1;
                  r_mask  <= '0;
                  r_cvld  <= 1'b1;
                  r_state <= S_REPORT;
               end
            end
            S_REPORT: begin
               if (cmp_ready) begin
                  r_last  <= r_id;
                  r_cvld  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = (reset && r_state == S_IDLE && w_win_vld) ? (NREQ'(1) << w_win_id) : '0;
   assign eng_start   = r_start;
   assign eng_head    = r_head;
   assign cmp_valid   = r_cvld;
   assign cmp_req_id  = r_id;
   assign cmp_tag     = r_tag;
   assign cmp_err     = r_err;
   assign cmp_timeout = r_tmo;
   assign busy        = r_busy;

endmodule

// File: doc/attention_head_scheduler.md
Name: attention_head_scheduler

Overview:
- Shares one single-head attention datapath engine between NREQ requesters.
- Accepts jobs by valid/ready handshake with round-robin arbitration. Each job carries a head mask and a tag.
- Issues one start pulse per selected head, lowest index first, and waits for each head's done. A watchdog covers an engine that never answers.
- Returns one completion record per job with sticky error and timeout flags. Sits between the attention requesters and the attention compute datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- HEADS, 4, number of attention heads per job (1..16)
- TAG_W, 4, job tag width
- TIMEOUT, 255, max cycles in WAIT before abort (1..65535)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  one-hot grant/accept; all zero while reset=0
- req_head_mask  in  NREQ*HEADS  heads to compute; requester r uses bits [r*HEADS +: HEADS]
- req_tag  in  NREQ*TAG_W  job tag; requester r uses bits [r*TAG_W +: TAG_W]
- eng_start  out  1  one-cycle start pulse to the engine
- eng_head  out  clog2(HEADS) max 1  head index; valid while eng_start=1, held stable through WAIT
- eng_done  in  1  engine finished the current head (single-cycle pulse)
- eng_err  in  1  engine error (e.g. zero normalising sum); sampled only with eng_done
- cmp_valid  out  1  completion record valid
- cmp_ready  in  1  consumer accepts completion
- cmp_req_id  out  clog2(NREQ) max 1  requester that owned the job
- cmp_tag  out  TAG_W  tag of the completed job
- cmp_err  out  1  OR of eng_err over all executed heads
- cmp_timeout  out  1  job aborted by the watchdog
- busy  out  1  state != IDLE

Behaviour:
- Reset: the state machine goes to IDLE. Every output is 0. The round-robin pointer resets so that requester 0 has the highest priority. Reset mid-operation abandons the job immediately; no completion is produced for it.
- States: IDLE, ISSUE, WAIT, REPORT.
- IDLE:
  - Winner is the first r with req_valid[r]=1, searching from (last_grant+1) mod NREQ upward with wrap-around.
  - req_ready is combinational: one-hot of the winner, zero if no req_valid.
  - On handshake, latch mask, tag and id; clear err and timeout.
  - If the latched mask is nonzero, go to ISSUE; if the mask is zero, go to REPORT with err=0 and timeout=0.
  - req_ready is 0 in every state other than IDLE.
- ISSUE:
  - eng_start=1 for exactly one cycle.
  - eng_head = lowest set bit of the remaining mask.
  - Clear the watchdog counter, then go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On eng_done=1: OR eng_err into err and clear the current head's mask bit. If the remaining mask is nonzero, go to ISSUE; otherwise go to REPORT.
  - If the counter equals TIMEOUT and eng_done=0: set timeout, discard the remaining heads, go to REPORT.
  - eng_done in the same cycle the counter reaches TIMEOUT counts as done; no timeout.
- REPORT:
  - cmp_valid=1, with all cmp_* fields held stable until cmp_ready=1.
  - On handshake: last_grant = latched id, go to IDLE.
  - cmp_ready may be held high continuously. cmp_valid never drops before the handshake.
- eng_done or eng_err outside WAIT is ignored. An engine pulse that arrives after a timeout is not attributed to any job.
- Latency:
  - Job accepted at edge T: eng_start is high during cycle T+1.
  - Done sampled at edge D: the next eng_start is high in cycle D+1, or cmp_valid is high from cycle D+1.
  - Minimum back-to-back job turnaround is one IDLE cycle.
- Changes on req_valid or req_head_mask while not in IDLE have no effect. A job is not retracted once accepted.

Test Plan:
- Reset released, req_valid[1]=1, mask=4'b1010, tag=5; engine answers done 3 cycles after each start.
  - Required response: req_ready=4'b0010 for one cycle.
  - eng_start with eng_head=1, then eng_start with eng_head=3.
  - cmp_valid with req_id=1, tag=5, err=0, timeout=0.
- All four requesters valid continuously, each with mask=4'b0001 and cmp_ready=1.
  - Required response: grants in the order 0,1,2,3,0, with exactly one start per job.
- Mask=4'b1111; engine returns eng_err=1 on head 2 only.
  - Required response: four starts with heads 0,1,2,3 in order; cmp_err=1, cmp_timeout=0.
- TIMEOUT=8, mask=4'b0011, engine never answers head 0.
  - Required response: timeout after 8 WAIT cycles; head 1 is never started.
  - cmp_timeout=1; a late eng_done is ignored.
- Mask=0 with tag=9.
  - Required response: no eng_start; cmp_valid is high the cycle after acceptance, with tag=9, err=0, timeout=0.
- Backpressure and reset:
  - cmp_ready=0 for 10 cycles: cmp_* stays stable and no new req_ready is asserted.
  - reset=0 asserted during WAIT: all outputs are 0 asynchronously. After release, requester 0 is granted first.
